lif_neuron_array: RTL and testbench

Parametrised layer of N_NEURONS leaky integrate-and-fire neurons sharing one binary spike input vector, each with its own ±1 weight row. It adds a configurable leak shift, threshold, refractory period, a timestep strobe and a membrane monitor port. The block sits between the input spike source (pins or upstream layer) and the spike consumer, and is configured through a simple register-write port.

---
 rtl/lif_neuron_array.sv | 124 ++++++++++++
 tb/tb_lif_neuron_array.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Layer of leaky integrate-and-fire neurons with +/-1 weights, shared spike input,
// configurable leak shift, threshold and refractory period, plus a membrane monitor.
module lif_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 8,
  parameter int U_BITS    = 8,
  parameter int REF_BITS  = 3,
  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int CFG_W = (N_INPUTS > U_BITS) ? N_INPUTS : U_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [N_INPUTS-1:0]  x,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [CFG_W-1:0]     cfg_data,
  input  logic [IDX_W-1:0]     mon_idx,
  output logic [N_NEURONS-1:0] spike_out,
  output logic                 out_valid,
  output logic [U_BITS-1:0]    mon_u
);

  // Two guard bits so sum + leaked never wraps before saturation.
  localparam int SW = U_BITS + 2;
  localparam logic signed [SW-1:0] ONE   = SW'(1);
  localparam logic signed [SW-1:0] U_MAX = SW'((2 ** (U_BITS - 1)) - 1);
  localparam logic signed [SW-1:0] U_MIN = -U_MAX - ONE;

  logic signed [U_BITS-1:0] threshold_reg;
  logic [2:0]               shift_reg;
  logic [REF_BITS-1:0]      refract_reg;
  logic signed [SW-1:0]     thr_ext;
  logic [N_NEURONS-1:0]     spike_next;
  logic [U_BITS-1:0]        u_all [N_NEURONS];

  assign thr_ext = {{2{threshold_reg[U_BITS-1]}}, threshold_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold_reg <= U_BITS'(5);
      shift_reg     <= 3'd0;
      refract_reg   <= '0;
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd1:    threshold_reg <= cfg_data[U_BITS-1:0];
        2'd2:    shift_reg     <= cfg_data[2:0];
        2'd3:    refract_reg   <= cfg_data[REF_BITS-1:0];
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
    logic [N_INPUTS-1:0]      w_reg;
    logic signed [U_BITS-1:0] u_reg;
    logic [REF_BITS-1:0]      ref_reg;
    logic signed [SW-1:0]     sum;
    logic signed [SW-1:0]     u_ext;
    logic signed [SW-1:0]     leaked;
    logic signed [SW-1:0]     v_raw;
    logic signed [SW-1:0]     v;
    logic                     fire;

    always_comb begin
      sum = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (x[i]) sum = w_reg[i] ? sum + ONE : sum - ONE;
      end
      u_ext  = {{2{u_reg[U_BITS-1]}}, u_reg};
      leaked = (shift_reg == 3'd0) ? u_ext : u_ext - (u_ext >>> shift_reg);
      v_raw  = leaked + sum;
      if (v_raw > U_MAX)      v = U_MAX;
      else if (v_raw < U_MIN) v = U_MIN;
      else                    v = v_raw;
      fire = (ref_reg == '0) && (v >= thr_ext);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        w_reg   <= '1;
        u_reg   <= '0;
        ref_reg <= '0;
      end else begin
        if (cfg_we && cfg_sel == 2'd0 && cfg_idx == IDX_W'(gi))
          w_reg <= cfg_data[N_INPUTS-1:0];
        if (in_valid) begin
          if (ref_reg != '0) begin
            u_reg   <= '0;
            ref_reg <= ref_reg - 1'b1;
          end else if (fire) begin
            u_reg   <= '0;
            ref_reg <= refract_reg;
          end else begin
            u_reg   <= v[U_BITS-1:0];
          end
        end
      end
    end

    assign spike_next[gi] = fire;
    assign u_all[gi]      = u_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) spike_out <= spike_next;
    end
  end

  // Out-of-range monitor index reads as zero.
  always_comb begin
    mon_u = '0;
    for (int n = 0; n < N_NEURONS; n++) begin
      if (mon_idx == IDX_W'(n)) mon_u = u_all[n];
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Randomised and directed bench for lif_neuron_array against an integer
// behavioural model of the neuron layer.
module tb_lif_neuron_array;
  localparam int N  = 4;
  localparam int NI = 8;
  localparam int UB = 8;
  localparam int RB = 3;
  localparam int UMAX = (1 << (UB - 1)) - 1;
  localparam int UMIN = -(1 << (UB - 1));

  logic          clk = 0;
  logic          rst_n = 0;
  logic          in_valid = 0;
  logic [NI-1:0] x = '0;
  logic          cfg_we = 0;
  logic [1:0]    cfg_sel = '0;
  logic [1:0]    cfg_idx = '0;
  logic [7:0]    cfg_data = '0;
  logic [1:0]    mon_idx = '0;
  logic [N-1:0]  spike_out;
  logic          out_valid;
  logic [UB-1:0] mon_u;

  int checks = 0;
  int errors = 0;

  // reference model state
  int            mu [N];
  int            mrc [N];
  logic [NI-1:0] mw [N];
  int            mthr, mshift, mrefr;
  logic [N-1:0]  msp;

  lif_neuron_array #(.N_NEURONS(N), .N_INPUTS(NI), .U_BITS(UB), .REF_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .mon_idx(mon_idx), .spike_out(spike_out), .out_valid(out_valid), .mon_u(mon_u)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int n = 0; n < N; n++) begin
      mu[n] = 0; mrc[n] = 0; mw[n] = '1;
    end
    mthr = 5; mshift = 0; mrefr = 0; msp = '0;
  endfunction

  function automatic void model_step(input logic [NI-1:0] xv);
    for (int n = 0; n < N; n++) begin
      int s, l, vv;
      if (mrc[n] > 0) begin
        msp[n] = 1'b0; mu[n] = 0; mrc[n] = mrc[n] - 1;
      end else begin
        s = 0;
        for (int i = 0; i < NI; i++) if (xv[i]) s += mw[n][i] ? 1 : -1;
        l  = (mshift == 0) ? mu[n] : mu[n] - (mu[n] >>> mshift);
        vv = l + s;
        if (vv > UMAX) vv = UMAX;
        if (vv < UMIN) vv = UMIN;
        if (vv >= mthr) begin
          msp[n] = 1'b1; mu[n] = 0; mrc[n] = mrefr;
        end else begin
          msp[n] = 1'b0; mu[n] = vv;
        end
      end
    end
  endfunction

  function automatic void model_cfg(input logic [1:0] sel, input logic [1:0] idx, input logic [7:0] data);
    int t;
    case (sel)
      2'd0: mw[idx] = data;
      2'd1: begin
        t = int'(data);
        if (t >= (1 << (UB - 1))) t -= (1 << UB);
        mthr = t;
      end
      2'd2: mshift = int'(data) & 7;
      default: mrefr = int'(data) & ((1 << RB) - 1);
    endcase
  endfunction

  task automatic check_all();
    chk("spike_out", int'(spike_out), int'(msp));
    for (int n = 0; n < N; n++) begin
      mon_idx = 2'(n);
      #1;
      chk($sformatf("mon_u[%0d]", n), int'($signed(mon_u)), mu[n]);
    end
  endtask

  task automatic cycle(input bit v, input logic [NI-1:0] xv, input bit we,
                       input logic [1:0] sel, input logic [1:0] idx, input logic [7:0] data);
    in_valid = v; x = xv; cfg_we = we; cfg_sel = sel; cfg_idx = idx; cfg_data = data;
    @(posedge clk);
    #1;
    in_valid = 0; cfg_we = 0;
    if (v) model_step(xv);
    if (we) model_cfg(sel, idx, data);
    chk("out_valid", int'(out_valid), int'(v));
    check_all();
  endtask

  task automatic step(input logic [NI-1:0] xv);
    cycle(1'b1, xv, 1'b0, 2'd0, 2'd0, 8'd0);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [1:0] idx, input logic [7:0] data);
    cycle(1'b0, '0, 1'b1, sel, idx, data);
  endtask

  task automatic mon0(input string tag, input int exp);
    mon_idx = 2'd0;
    #1;
    chk(tag, int'($signed(mon_u)), exp);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    check_all();
    @(posedge clk); #1;
    rst_n = 1;

    // integrate then fire with defaults
    step(8'h07);
    mon0("t1_u3", 3);
    step(8'h07);
    chk("t1_spike", int'(spike_out), 4'b1111);
    cycle(1'b0, '0, 1'b0, 2'd0, 2'd0, 8'd0);

    // all -1 weights: saturate at the negative rail
    cfg(2'd0, 2'd1, 8'h00);
    for (int k = 0; k < 20; k++) step(8'hFF);
    mon_idx = 2'd1; #1;
    chk("t2_sat", int'($signed(mon_u)), -128);

    // leak with shift=1
    cfg(2'd2, 2'd0, 8'd1);
    cfg(2'd1, 2'd0, 8'd100);
    step(8'h0F); mon0("t3_u4", 4);
    step(8'h00); mon0("t3_u2", 2);
    step(8'h00); mon0("t3_u1a", 1);
    step(8'h00); mon0("t3_u1b", 1);

    // refractory period
    cfg(2'd2, 2'd0, 8'd0);
    cfg(2'd1, 2'd0, 8'd5);
    cfg(2'd3, 2'd0, 8'd2);
    for (int k = 0; k < 5; k++) step(8'hFF);

    // config in the same cycle as a timestep
    cfg(2'd3, 2'd0, 8'd0);
    for (int k = 0; k < 3; k++) step(8'h00);
    cycle(1'b1, 8'hFF, 1'b1, 2'd1, 2'd0, 8'd20);
    step(8'hFF);

    // asynchronous reset between edges
    step(8'hFF);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    check_all();
    @(posedge clk); #1;
    rst_n = 1;
    step(8'h07);
    mon0("arst_u3", 3);

    // randomised traffic
    for (int k = 0; k < 300; k++) begin
      int r;
      logic [1:0] sel;
      logic [7:0] d;
      r   = int'($urandom_range(0, 9));
      sel = 2'($urandom_range(0, 3));
      d   = 8'($urandom);
      if (sel == 2'd1 && $urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 15));
      if (r <= 5)      step(8'($urandom));
      else if (r <= 8) cycle(1'($urandom), 8'($urandom), 1'b1, sel, 2'($urandom), d);
      else             cycle(1'b0, '0, 1'b0, 2'd0, 2'd0, 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
